// File: rtl/mem_bus_pkg.sv
// Shared types for the C1/C2 cache and memory protocols and for the memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        C2_NOP      = 2'd0,
        C2_RESPONSE = 2'd1,
        C2_READ     = 2'd2,
        C2_WRITE    = 2'd3
    } c2_cmd_t;

    typedef enum logic [2:0] {
        C1_NOP             = 3'd0,
        C1_READ8           = 3'd1,
        C1_READ16          = 3'd2,
        C1_READ32          = 3'd3,
        C1_INVALIDATE_LINE = 3'd4,
        C1_WRITE8          = 3'd5,
        C1_WRITE16         = 3'd6,
        C1_WRITE32         = 3'd7
    } c1_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        BURST     = 2'd3
    } arb_state_t;

    function automatic logic [1:0] onehot2(logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        unique case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-client round-robin arbiter for one C2 main-memory port, one line burst in flight.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT_RESP watchdog and the rq_err outputs.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned BUS_SIZE       = 16,
    parameter int unsigned ADDR_SIZE      = 15,
`ifdef MEM_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
    parameter int unsigned BURST_LEN      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           rq_cmd   [2],
    input  logic [ADDR_SIZE-1:0] rq_addr  [2],
    input  logic [BUS_SIZE-1:0]  rq_wdata [2],
    output logic [1:0]           rq_grant,
    output logic [1:0]           rq_rsp,
    output logic [BUS_SIZE-1:0]  rq_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic [1:0]           rq_err,
`endif
    output logic [1:0]           mem_cmd_o,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [BUS_SIZE-1:0]  mem_wdata,
    input  logic [1:0]           mem_cmd_i,
    input  logic [BUS_SIZE-1:0]  mem_rdata
);

    localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

    arb_state_t           state_q, state_d;
    logic                 owner_q, owner_d;
    c2_cmd_t              cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 last_grant_q, last_grant_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BUS_SIZE-1:0]  rdata_q, rdata_d;
    logic [1:0]           rsp_rd_q, rsp_rd_d;

    logic [1:0]      req_vec;
    logic            pick_winner;
    logic            pick_valid;
    logic            in_xfer;
    logic            beat_fire;
    logic [CntW-1:0] beat_idx;
    logic            last_beat;
    logic            wd_expire;

    assign req_vec = {rq_cmd[1] != C2_NOP, rq_cmd[0] != C2_NOP};

    rr_pick2 u_pick (
        .req_i        (req_vec),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    // The RESPONSE that ends WAIT_RESP is already beat 0 of the burst.
    assign in_xfer   = (state_q == WAIT_RESP) || (state_q == BURST);
    assign beat_fire = in_xfer && (mem_cmd_i == C2_RESPONSE);
    assign beat_idx  = (state_q == WAIT_RESP) ? '0 : cnt_q;
    assign last_beat = beat_fire && (beat_idx == LastBeat);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;

    // Zero in ISSUE, so the count restarts on every entry to WAIT_RESP.
    assign wd_d      = (state_q == WAIT_RESP) ? wd_q + 8'd1 : 8'd0;
    assign wd_expire = (state_q == WAIT_RESP) && !beat_fire
                       && (wd_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            cmd_q        <= C2_NOP;
            addr_q       <= '0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rsp_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            rsp_rd_q     <= rsp_rd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    cmd_d   = c2_cmd_t'(rq_cmd[pick_winner]);
                    addr_d  = rq_addr[pick_winner];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_RESP;
            WAIT_RESP, BURST: begin
                if (last_beat || wd_expire) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                    cnt_d        = '0;
                end else if (beat_fire) begin
                    state_d = BURST;
                    cnt_d   = beat_idx + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rq_grant  = '0;
        rq_rsp    = rsp_rd_q;
        mem_cmd_o = C2_NOP;
        mem_wdata = '0;
        rsp_rd_d  = '0;
        rdata_d   = rdata_q;
        if (state_q != IDLE) begin
            rq_grant = onehot2(owner_q);
        end
        if (state_q == ISSUE) begin
            mem_cmd_o = cmd_q;
        end
        if (in_xfer) begin
            mem_wdata = rq_wdata[owner_q];
        end
        // Read beats are acknowledged one cycle late with the data; write beats at once.
        if (beat_fire) begin
            if (cmd_q == C2_READ) begin
                rsp_rd_d = onehot2(owner_q);
                rdata_d  = mem_rdata;
            end else begin
                rq_rsp = rq_rsp | onehot2(owner_q);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    assign rq_err = wd_expire ? onehot2(owner_q) : 2'b00;
`endif

    assign mem_addr = addr_q;
    assign rq_rdata = rdata_q;

endmodule
